// File: rtl/volume_ramp_ctrl.sv
// Volume gain owner: clamped target requests, click-free ramping every RAMP_DIV frames, mute sequencing.
// Define VOLRAMP_SOFT_MUTE_EN to ramp through mute/unmute; otherwise mute/unmute jump in one clock.
module volume_ramp_ctrl #(
  parameter int GAIN_W     = 32,
  parameter int MAX_GAIN   = 16,
  parameter int UNITY_GAIN = 1,
  parameter int STEP       = 1,
  parameter int RAMP_DIV   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sampleStrobe,
  input  logic                     reqValid,
  input  logic signed [GAIN_W-1:0] reqGain,
  output logic                     reqReady,
  input  logic                     muteToggle,
  output logic signed [GAIN_W-1:0] gain,
  output logic                     ramping,
  output logic                     muted
);

  // state     | meaning
  // IDLE      | gain == target, requests accepted
  // RAMP      | stepping toward requested target
  // MUTING    | heading to 0, requests held off
  // MUTED     | gain 0, requests only update savedGain
  // UNMUTING  | heading back to savedGain, requests held off
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RAMP     = 3'd1;
  localparam logic [2:0] ST_MUTING   = 3'd2;
  localparam logic [2:0] ST_MUTED    = 3'd3;
  localparam logic [2:0] ST_UNMUTING = 3'd4;

  localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);

  localparam logic signed [GAIN_W-1:0] G_MAX   = GAIN_W'(MAX_GAIN);
  localparam logic signed [GAIN_W-1:0] G_UNITY = GAIN_W'(UNITY_GAIN);
  localparam logic signed [GAIN_W-1:0] G_STEP  = GAIN_W'(STEP);
  localparam logic signed [GAIN_W-1:0] G_NSTEP = GAIN_W'(-STEP);

`ifdef VOLRAMP_SOFT_MUTE_EN
  localparam bit HARD_MUTE = 1'b0;
`else
  localparam bit HARD_MUTE = 1'b1;
`endif

  logic [2:0]               r_state;
  logic [DIV_W-1:0]         r_div_cnt;
  logic signed [GAIN_W-1:0] r_gain;
  logic signed [GAIN_W-1:0] r_target;
  logic signed [GAIN_W-1:0] r_saved;

  logic                     w_tick;
  logic                     w_accept;
  logic                     w_force;
  logic [2:0]               w_state_nxt;
  logic signed [GAIN_W-1:0] w_clamped;
  logic signed [GAIN_W-1:0] w_target_nxt;
  logic signed [GAIN_W-1:0] w_saved_nxt;
  logic signed [GAIN_W-1:0] w_diff;
  logic signed [GAIN_W-1:0] w_stepped;
  logic signed [GAIN_W-1:0] w_gain_nxt;

  assign reqReady = (r_state != ST_MUTING) && (r_state != ST_UNMUTING);
  assign w_accept = reqValid && reqReady;
  assign w_tick   = sampleStrobe && (r_div_cnt == DIV_LAST);
  assign gain     = r_gain;
  assign ramping  = (r_gain != r_target);
  assign muted    = (r_state == ST_MUTED);

  always_comb begin
    w_clamped = reqGain;
    if (reqGain[GAIN_W-1])
      w_clamped = '0;
    else if (reqGain > G_MAX)
      w_clamped = G_MAX;
  end

  // Target is resolved first so a coincident tick steps toward the new target.
  always_comb begin
    w_target_nxt = r_target;
    w_saved_nxt  = r_saved;
    w_state_nxt  = r_state;
    w_force      = 1'b0;
    if (w_accept)
      w_saved_nxt = w_clamped;
    case (r_state)
      ST_IDLE, ST_RAMP: begin
        if (w_accept)
          w_target_nxt = w_clamped;
        if (muteToggle) begin
          w_state_nxt  = ST_MUTING;
          w_target_nxt = '0;
          w_force      = 1'b1;
        end
      end
      ST_MUTING, ST_MUTED: begin
        if (muteToggle) begin
          w_state_nxt  = ST_UNMUTING;
          w_target_nxt = w_saved_nxt;
          w_force      = 1'b1;
        end
      end
      ST_UNMUTING: begin
        if (muteToggle) begin
          w_state_nxt  = ST_MUTING;
          w_target_nxt = '0;
          w_force      = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_diff = w_target_nxt - r_gain;
    if (w_diff > G_STEP)
      w_stepped = r_gain + G_STEP;
    else if (w_diff < G_NSTEP)
      w_stepped = r_gain - G_STEP;
    else
      w_stepped = w_target_nxt;

    if (HARD_MUTE && w_force)
      w_gain_nxt = w_target_nxt;
    else if (w_tick)
      w_gain_nxt = w_stepped;
    else
      w_gain_nxt = r_gain;

    if (!muteToggle) begin
      case (r_state)
        ST_IDLE, ST_RAMP:
          w_state_nxt = (w_gain_nxt != w_target_nxt) ? ST_RAMP : ST_IDLE;
        ST_MUTING:
          if (w_gain_nxt == '0) w_state_nxt = ST_MUTED;
        ST_UNMUTING:
          if (w_gain_nxt == w_target_nxt) w_state_nxt = ST_IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_div_cnt <= '0;
      r_gain    <= G_UNITY;
      r_target  <= G_UNITY;
      r_saved   <= G_UNITY;
    end else begin
      r_state  <= w_state_nxt;
      r_gain   <= w_gain_nxt;
      r_target <= w_target_nxt;
      r_saved  <= w_saved_nxt;
      if (sampleStrobe)
        r_div_cnt <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_volume_ramp_ctrl.sv
// Self-checking bench for volume_ramp_ctrl: directed scenarios plus random traffic against a frame-counting model.
module tb_volume_ramp_ctrl;
  localparam int GAIN_W   = 32;
  localparam int MAX_GAIN = 16;
  localparam int UNITY    = 1;
  localparam int STEP     = 1;
  localparam int RAMP_DIV = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sampleStrobe = 1'b0;
  logic reqValid = 1'b0;
  logic muteToggle = 1'b0;
  logic signed [GAIN_W-1:0] reqGain = '0;
  logic reqReady;
  logic ramping;
  logic muted;
  logic signed [GAIN_W-1:0] gain;

  int checks = 0;
  int errors = 0;

  typedef enum int {M_NORMAL, M_MUTING, M_MUTED, M_UNMUTING} mode_t;
  mode_t m_mode;
  int m_gain, m_target, m_saved, m_frames;

  volume_ramp_ctrl #(
    .GAIN_W(GAIN_W), .MAX_GAIN(MAX_GAIN), .UNITY_GAIN(UNITY), .STEP(STEP), .RAMP_DIV(RAMP_DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sampleStrobe(sampleStrobe), .reqValid(reqValid),
    .reqGain(reqGain), .reqReady(reqReady), .muteToggle(muteToggle),
    .gain(gain), .ramping(ramping), .muted(muted)
  );

  always #5 clk = ~clk;

  function automatic int clamp(int v);
    if (v < 0) return 0;
    if (v > MAX_GAIN) return MAX_GAIN;
    return v;
  endfunction

  task automatic model_reset();
    m_mode = M_NORMAL; m_gain = UNITY; m_target = UNITY; m_saved = UNITY; m_frames = 0;
  endtask

  // Frame count since reset decides ticks; every RAMP_DIV-th frame is a tick.
  task automatic model_clock(bit s, bit v, int r, bit t);
    bit ready, tick, jump;
    ready = (m_mode == M_NORMAL) || (m_mode == M_MUTED);
    tick = 1'b0;
    if (s) begin
      m_frames++;
      tick = (m_frames % RAMP_DIV) == 0;
    end
    if (v && ready) begin
      m_saved = clamp(r);
      if (m_mode == M_NORMAL) m_target = m_saved;
    end
    if (t) begin
      if (m_mode == M_NORMAL || m_mode == M_UNMUTING) begin
        m_mode = M_MUTING; m_target = 0;
      end else begin
        m_mode = M_UNMUTING; m_target = m_saved;
      end
    end
`ifdef VOLRAMP_SOFT_MUTE_EN
    jump = 1'b0;
`else
    jump = t;
`endif
    if (jump)
      m_gain = m_target;
    else if (tick && m_gain != m_target) begin
      if ((m_target - m_gain) <= STEP && (m_gain - m_target) <= STEP) m_gain = m_target;
      else if (m_target > m_gain) m_gain = m_gain + STEP;
      else m_gain = m_gain - STEP;
    end
    if (!t) begin
      if (m_mode == M_MUTING && m_gain == 0) m_mode = M_MUTED;
      else if (m_mode == M_UNMUTING && m_gain == m_target) m_mode = M_NORMAL;
    end
  endtask

  task automatic drive(bit s, bit v, int r, bit t);
    @(negedge clk);
    sampleStrobe = s; reqValid = v; reqGain = r; muteToggle = t;
    @(posedge clk);
    model_clock(s, v, r, t);
    #1;
    sampleStrobe = 1'b0; reqValid = 1'b0; muteToggle = 1'b0;
  endtask

  task automatic align();
    for (int k = 0; k < RAMP_DIV && (m_frames % RAMP_DIV) != 0; k++) drive(1, 0, 0, 0);
  endtask

  task automatic settle();
    for (int k = 0; k < 400 && (ramping || !reqReady); k++) drive(1, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #12;
    checks++; if (gain !== UNITY) begin errors++; $display("FAIL reset_gain got %0d want %0d", gain, UNITY); end
    checks++; if (ramping !== 1'b0 || muted !== 1'b0 || reqReady !== 1'b1) begin
      errors++; $display("FAIL reset_flags got ramping=%b muted=%b ready=%b want 0 0 1", ramping, muted, reqReady); end
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 10; k++) drive(1, 0, 0, 0);
    checks++; if (gain !== m_gain || gain !== UNITY) begin errors++; $display("FAIL hold_gain got %0d want %0d", gain, UNITY); end
    checks++; if (ramping !== 1'b0 || muted !== 1'b0 || reqReady !== 1'b1) begin
      errors++; $display("FAIL hold_flags got ramping=%b muted=%b ready=%b want 0 0 1", ramping, muted, reqReady); end
  endtask

  task automatic test_ramp_up();
    int n;
    align();
    drive(0, 1, 8, 0);
    checks++; if (gain !== UNITY || ramping !== 1'b1) begin
      errors++; $display("FAIL ramp_start got gain=%0d ramping=%b want %0d 1", gain, ramping, UNITY); end
    n = 0;
    while (gain !== 8 && n < 100) begin
      drive(1, 0, 0, 0); n++;
      checks++; if (gain !== m_gain) begin errors++; $display("FAIL ramp_step got %0d want %0d", gain, m_gain); end
    end
    checks++; if (n != 7 * RAMP_DIV) begin errors++; $display("FAIL ramp_strobes got %0d want %0d", n, 7 * RAMP_DIV); end
    checks++; if (ramping !== 1'b0) begin errors++; $display("FAIL ramp_done got ramping=%b want 0", ramping); end
  endtask

  task automatic test_clamp();
    drive(0, 1, 100, 0);
    settle();
    checks++; if (gain !== MAX_GAIN || gain !== m_gain) begin errors++; $display("FAIL clamp_high got %0d want %0d", gain, MAX_GAIN); end
    drive(0, 1, -5, 0);
    settle();
    checks++; if (gain !== 0 || gain !== m_gain) begin errors++; $display("FAIL clamp_low got %0d want 0", gain); end
  endtask

  task automatic test_retarget();
    int peak;
    drive(0, 1, 12, 0);
    for (int k = 0; k < 200 && gain !== 6; k++) drive(1, 0, 0, 0);
    checks++; if (gain !== 6) begin errors++; $display("FAIL retarget_reach got %0d want 6", gain); end
    drive(0, 1, 5, 0);
    peak = 6;
    for (int k = 0; k < 200 && ramping; k++) begin
      drive(1, 0, 0, 0);
      if (gain > peak) peak = gain;
    end
    checks++; if (gain !== 5 || gain !== m_gain) begin errors++; $display("FAIL retarget_final got %0d want 5", gain); end
    checks++; if (peak != 6) begin errors++; $display("FAIL retarget_peak got %0d want 6", peak); end
  endtask

  task automatic test_mute();
    drive(0, 1, 8, 0);
    settle();
    align();
    drive(0, 0, 0, 1);
    checks++; if (reqReady !== 1'b0) begin errors++; $display("FAIL mute_ready got %b want 0", reqReady); end
`ifdef VOLRAMP_SOFT_MUTE_EN
    begin
      int n;
      n = 0;
      while (muted !== 1'b1 && n < 200) begin drive(1, 0, 0, 0); n++; end
      checks++; if (n != 8 * RAMP_DIV) begin errors++; $display("FAIL mute_strobes got %0d want %0d", n, 8 * RAMP_DIV); end
    end
`else
    checks++; if (gain !== 0 || muted !== 1'b0) begin errors++; $display("FAIL mute_jump got gain=%0d muted=%b want 0 0", gain, muted); end
    drive(0, 0, 0, 0);
`endif
    checks++; if (gain !== 0 || muted !== 1'b1 || reqReady !== 1'b1) begin
      errors++; $display("FAIL muted_state got gain=%0d muted=%b ready=%b want 0 1 1", gain, muted, reqReady); end
    drive(0, 1, 3, 0);
    for (int k = 0; k < 3 * RAMP_DIV; k++) drive(1, 0, 0, 0);
    checks++; if (gain !== 0 || muted !== 1'b1) begin errors++; $display("FAIL muted_req got gain=%0d muted=%b want 0 1", gain, muted); end
    drive(0, 0, 0, 1);
    checks++; if (muted !== 1'b0 || reqReady !== 1'b0) begin errors++; $display("FAIL unmute_start got muted=%b ready=%b want 0 0", muted, reqReady); end
    settle();
    checks++; if (gain !== 3 || gain !== m_gain || reqReady !== 1'b1) begin
      errors++; $display("FAIL unmute_final got gain=%0d ready=%b want 3 1", gain, reqReady); end
  endtask

  task automatic test_reversal();
    drive(0, 1, 8, 0);
    settle();
    drive(0, 0, 0, 1);
`ifdef VOLRAMP_SOFT_MUTE_EN
    for (int k = 0; k < 200 && gain !== 5; k++) begin
      drive(1, 0, 0, 0);
      checks++; if (reqReady !== 1'b0) begin errors++; $display("FAIL rev_mute_ready got %b want 0", reqReady); end
    end
    checks++; if (gain !== 5) begin errors++; $display("FAIL rev_reach got %0d want 5", gain); end
    drive(0, 0, 0, 1);
    for (int k = 0; k < 200 && gain !== 8; k++) begin
      checks++; if (reqReady !== 1'b0 || muted !== 1'b0) begin
        errors++; $display("FAIL rev_unmute got ready=%b muted=%b want 0 0", reqReady, muted); end
      drive(1, 0, 0, 0);
      checks++; if (gain !== m_gain) begin errors++; $display("FAIL rev_step got %0d want %0d", gain, m_gain); end
    end
`else
    checks++; if (gain !== 0 || reqReady !== 1'b0) begin errors++; $display("FAIL rev_jump0 got gain=%0d ready=%b want 0 0", gain, reqReady); end
    drive(0, 0, 0, 1);
    checks++; if (gain !== 8 || reqReady !== 1'b0) begin errors++; $display("FAIL rev_jump8 got gain=%0d ready=%b want 8 0", gain, reqReady); end
`endif
    drive(0, 0, 0, 0);
    checks++; if (gain !== 8 || ramping !== 1'b0 || reqReady !== 1'b1) begin
      errors++; $display("FAIL rev_final got gain=%0d ramping=%b ready=%b want 8 0 1", gain, ramping, reqReady); end
  endtask

  task automatic test_async_reset();
    drive(0, 1, 5, 0);
    settle();
    drive(0, 1, 12, 0);
    checks++; if (gain !== 5 || ramping !== 1'b1) begin errors++; $display("FAIL ar_setup got gain=%0d ramping=%b want 5 1", gain, ramping); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (gain !== UNITY || ramping !== 1'b0 || reqReady !== 1'b1 || muted !== 1'b0) begin
      errors++; $display("FAIL ar_async got gain=%0d ramping=%b ready=%b muted=%b want 1 0 1 0", gain, ramping, reqReady, muted); end
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    drive(1, 0, 0, 0);
    checks++; if (gain !== UNITY || ramping !== 1'b0) begin errors++; $display("FAIL ar_release got gain=%0d ramping=%b want 1 0", gain, ramping); end
  endtask

  task automatic test_random();
    bit s, v, t;
    int r;
    for (int i = 0; i < 1500; i++) begin
      s = ($urandom_range(0, 1) == 1);
      v = ($urandom_range(0, 4) == 0);
      t = ($urandom_range(0, 29) == 0);
      r = $urandom_range(0, 60) - 20;
      drive(s, v, r, t);
      checks++;
      if (gain !== m_gain || ramping !== (m_gain != m_target) || muted !== (m_mode == M_MUTED)
          || reqReady !== (m_mode == M_NORMAL || m_mode == M_MUTED)) begin
        errors++;
        $display("FAIL random cyc=%0d got gain=%0d ramp=%b muted=%b ready=%b want %0d %b %b %b", i, gain, ramping, muted,
                 reqReady, m_gain, (m_gain != m_target), (m_mode == M_MUTED), (m_mode == M_NORMAL || m_mode == M_MUTED));
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_clamp();
    test_retarget();
    test_mute();
    test_reversal();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout reached without completing the test sequence");
    $fatal(1, "timeout");
  end
endmodule
